// File: rtl/alu_seq_top.sv
// Debounced push-to-execute ALU with registered result, carry/borrow and unsigned comparator.
// The result is shown as hex on a scanned, active-low seven-segment display.
module alu_seq_top #(
    parameter int          WIDTH        = 8,
    parameter logic [15:0] DEBOUNCE_CYC = 16'd50000,
    parameter logic [15:0] REFRESH_DIV  = 16'd50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       sw_x,
    input  logic [WIDTH-1:0]       sw_y,
    input  logic [1:0]             op_sel,
    input  logic                   btn_go,
    output logic [WIDTH-1:0]       result,
    output logic                   carry,
    output logic [2:0]             comparator_out,
    output logic                   done,
    output logic                   busy,
    output logic [7:0]             ssd,
    output logic [WIDTH/4-1:0]     an
);
    localparam int NDIG  = WIDTH / 4;
    localparam int DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [2:0] {S_IDLE, S_PRESS, S_EXEC, S_CALC, S_RELEASE} state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync2_q;
    logic [15:0]        deb_q, deb_d;
    logic [WIDTH-1:0]   x_q, y_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [2:0]         cmp_q, cmp_d;
    logic               done_q;
    logic [15:0]        scan_q;
    logic [DIG_W-1:0]   dig_q, dig_d;
    logic [NDIG-1:0]    an_q;
    logic [WIDTH:0]     sum_w, diff_w;
    logic [3:0]         nibble;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= S_IDLE;
            deb_q   <= '0;
        end else begin
            sync1_q <= btn_go;
            sync2_q <= sync1_q;
            state_q <= state_d;
            deb_q   <= deb_d;
        end
    end

    // PRESS leaves on the cycle its incremented count reaches DEBOUNCE_CYC-1;
    // RELEASE needs DEBOUNCE_CYC consecutive low cycles.
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        case (state_q)
            S_IDLE: begin
                if (sync2_q) begin
                    state_d = S_PRESS;
                    deb_d   = '0;
                end
            end
            S_PRESS: begin
                if (!sync2_q) begin
                    state_d = S_IDLE;
                    deb_d   = '0;
                end else if (deb_q + 16'd1 >= DEBOUNCE_CYC - 16'd1) begin
                    state_d = S_EXEC;
                    deb_d   = '0;
                end else begin
                    deb_d = deb_q + 16'd1;
                end
            end
            S_EXEC: state_d = S_CALC;
            S_CALC: begin
                state_d = S_RELEASE;
                deb_d   = '0;
            end
            S_RELEASE: begin
                if (sync2_q) begin
                    deb_d = '0;
                end else if (deb_q >= DEBOUNCE_CYC - 16'd1) begin
                    state_d = S_IDLE;
                    deb_d   = '0;
                end else begin
                    deb_d = deb_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                deb_d   = '0;
            end
        endcase
    end

    always_comb begin
        sum_w   = {1'b0, x_q} + {1'b0, y_q};
        diff_w  = {1'b0, x_q} - {1'b0, y_q};
        res_d   = '0;
        carry_d = 1'b0;
        case (op_q)
            2'b00:   {carry_d, res_d} = sum_w;
            2'b01:   {carry_d, res_d} = diff_w;
            2'b10:   res_d = x_q & y_q;
            default: res_d = x_q ^ y_q;
        endcase
        if (x_q > y_q)       cmp_d = 3'b100;
        else if (x_q == y_q) cmp_d = 3'b010;
        else                 cmp_d = 3'b001;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            op_q    <= 2'b00;
            res_q   <= '0;
            carry_q <= 1'b0;
            cmp_q   <= 3'b000;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == S_CALC);
            if (state_q == S_EXEC) begin
                x_q  <= sw_x;
                y_q  <= sw_y;
                op_q <= op_sel;
            end
            if (state_q == S_CALC) begin
                res_q   <= res_d;
                carry_q <= carry_d;
                cmp_q   <= cmp_d;
            end
        end
    end

    assign dig_d = (dig_q == DIG_W'(NDIG - 1)) ? '0 : dig_q + 1'b1;

    // an is registered together with the digit index so the enables switch cleanly on wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q <= '0;
            dig_q  <= '0;
            an_q   <= ~NDIG'(1);
        end else if (scan_q == REFRESH_DIV - 16'd1) begin
            scan_q <= '0;
            dig_q  <= dig_d;
            an_q   <= ~(NDIG'(1) << dig_d);
        end else begin
            scan_q <= scan_q + 16'd1;
        end
    end

    always_comb begin
        nibble = res_q[4*int'(dig_q) +: 4];
        ssd    = {~(carry_q && (dig_q == DIG_W'(NDIG - 1))), hex7(nibble)};
    end

    assign result         = res_q;
    assign carry          = carry_q;
    assign comparator_out = cmp_q;
    assign done           = done_q;
    assign busy           = (state_q != S_IDLE);
    assign an             = an_q;

endmodule
